// File: rtl/matmul_operand_loader.sv
// Streaming operand loader for the 8x8 matrix-multiply engine: assembles A (m x k) and B (k x n)
// into zero-padded row-major buffers and presents them, frozen, until the engine accepts.
module matmul_operand_loader #(
    parameter int DATA_W = 16,
    parameter int DIM    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [3:0]                 cfg_m_dim,
    input  logic [3:0]                 cfg_n_dim,
    input  logic [3:0]                 cfg_k_dim,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_valid,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [DIM*DIM*DATA_W-1:0]  mm_matrix_a,
    output logic [DIM*DIM*DATA_W-1:0]  mm_matrix_b,
    output logic [3:0]                 mm_m_dim,
    output logic [3:0]                 mm_n_dim,
    output logic [3:0]                 mm_k_dim,
    output logic                       mm_valid,
    input  logic                       mm_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 dbg_state
);

    localparam int CW    = $clog2(DIM);
    localparam int IDX_W = 2 * CW;
    localparam logic [3:0] DIM_MAX = 4'(DIM);

    // Streams: a beat on s_* happens on a rising edge where s_valid && s_ready; the engine side
    // transfers on a rising edge where mm_valid && mm_ready, and mm_valid never drops before that.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD_A  = 2'd1,
        ST_LOAD_B  = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic [3:0]          r_m;
    logic [3:0]          r_n;
    logic [3:0]          r_k;
    logic                r_s_ready;
    logic                r_mm_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_a [DIM*DIM];
    logic [DATA_W-1:0]   r_b [DIM*DIM];

    logic                w_cfg_ok;
    logic                w_beat;
    logic [3:0]          w_col_lim;
    logic [3:0]          w_row_lim;
    logic                w_col_last;
    logic                w_row_last;
    logic [IDX_W-1:0]    w_idx;

    assign w_cfg_ok = (cfg_m_dim != 4'd0) && (cfg_m_dim <= DIM_MAX) &&
                      (cfg_n_dim != 4'd0) && (cfg_n_dim <= DIM_MAX) &&
                      (cfg_k_dim != 4'd0) && (cfg_k_dim <= DIM_MAX);

    assign w_beat = s_valid && r_s_ready;

    // A walks m rows of k columns; B walks k rows of n columns.
    assign w_col_lim  = (r_state == ST_LOAD_A) ? r_k : r_n;
    assign w_row_lim  = (r_state == ST_LOAD_A) ? r_m : r_k;
    assign w_col_last = (4'(r_col) == (w_col_lim - 4'd1));
    assign w_row_last = (4'(r_row) == (w_row_lim - 4'd1));
    assign w_idx      = {r_row, r_col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_s_ready  <= 1'b0;
            r_mm_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < DIM*DIM; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_m       <= cfg_m_dim;
                            r_n       <= cfg_n_dim;
                            r_k       <= cfg_k_dim;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_s_ready <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= ST_LOAD_A;
                            for (int i = 0; i < DIM*DIM; i++) begin
                                r_a[i] <= '0;
                                r_b[i] <= '0;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                ST_LOAD_A: begin
                    if (w_beat) begin
                        r_a[w_idx] <= s_data;
                        // s_last can never legitimately fall inside A, so it always aborts here.
                        if (s_last) begin
                            r_err     <= 1'b1;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row   <= '0;
                                r_state <= ST_LOAD_B;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end

                ST_LOAD_B: begin
                    if (w_beat) begin
                        r_b[w_idx] <= s_data;
                        if (w_row_last && w_col_last) begin
                            r_s_ready  <= 1'b0;
                            r_mm_valid <= 1'b1;
                            r_err      <= !s_last;
                            r_state    <= ST_PRESENT;
                        end else if (s_last) begin
                            r_err     <= 1'b1;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end

                ST_PRESENT: begin
                    if (mm_ready) begin
                        r_mm_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < DIM*DIM; g++) begin : g_pack
        assign mm_matrix_a[g*DATA_W +: DATA_W] = r_a[g];
        assign mm_matrix_b[g*DATA_W +: DATA_W] = r_b[g];
    end

    assign s_ready   = r_s_ready;
    assign mm_valid  = r_mm_valid;
    assign mm_m_dim  = r_m;
    assign mm_n_dim  = r_n;
    assign mm_k_dim  = r_k;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule
